// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Fetch-stage dynamic branch predictor. Direct-mapped table of
//                branch-target entries (valid, tag, target, 2-bit saturating
//                counter). Combinational lookup from PCF, trained from execute,
//                with saturating branch / mispredict performance counters.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              : clock, rising edge
//    rst              : asynchronous active-low reset
//    PCF              : fetch PC to look up
//    predict_taken_F  : taken prediction for PCF
//    PredictTargetF   : predicted target if taken, else PCF+4
//    UpdateE          : execute holds a valid resolved branch/jump
//    IsJumpE          : resolved instruction is unconditional (JAL/JALR)
//    ActualTakenE     : real outcome in execute
//    PCE              : PC of the instruction in execute
//    TargetE          : real target computed in execute
//    predict_taken_E  : prediction that was made for that instruction
//    MispredictE      : UpdateE && (predict_taken_E != ActualTakenE)
//    BranchCount      : number of resolved updates (saturating)
//    MispredictCount  : number of mispredictions (saturating)
// ============================================================================
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          PCF,
  output logic                 predict_taken_F,
  output logic [31:0]          PredictTargetF,
  input  logic                 UpdateE,
  input  logic                 IsJumpE,
  input  logic                 ActualTakenE,
  input  logic [31:0]          PCE,
  input  logic [31:0]          TargetE,
  input  logic                 predict_taken_E,
  output logic                 MispredictE,
  output logic [CNT_WIDTH-1:0] BranchCount,
  output logic [CNT_WIDTH-1:0] MispredictCount
);

  localparam int                 c_DEPTH = 1 << INDEX_BITS;
  localparam int                 c_TAG_W = 32 - INDEX_BITS - 2;
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Table storage. Only valid and counter bits are reset; tag and target are
  // qualified by valid so they may power up as anything.
  logic                 r_valid  [c_DEPTH];
  logic [1:0]           r_ctr    [c_DEPTH];
  logic [c_TAG_W-1:0]   r_tag    [c_DEPTH];
  logic [31:0]          r_target [c_DEPTH];

  logic [CNT_WIDTH-1:0] r_branch_cnt;
  logic [CNT_WIDTH-1:0] r_mispred_cnt;

  logic [INDEX_BITS-1:0] w_idxF;
  logic [c_TAG_W-1:0]    w_tagF;
  logic                  w_hitF;
  logic [INDEX_BITS-1:0] w_idxE;
  logic [c_TAG_W-1:0]    w_tagE;
  logic                  w_hitE;
  logic [1:0]            w_ctr_cur;
  logic [1:0]            w_ctr_next;
  logic                  w_alloc;
  logic                  w_tgt_we;
  logic                  w_unused_pce_lsb;

  // PC[1:0] never participates in indexing or tagging.
  assign w_unused_pce_lsb = ^PCE[1:0];

  // ---------------------------------------------------------------- lookup
  assign w_idxF = PCF[INDEX_BITS+1:2];
  assign w_tagF = PCF[31:INDEX_BITS+2];
  assign w_hitF = r_valid[w_idxF] && (r_tag[w_idxF] == w_tagF);

  assign predict_taken_F = w_hitF && r_ctr[w_idxF][1];
  assign PredictTargetF  = predict_taken_F ? r_target[w_idxF] : (PCF + 32'd4);

  // ---------------------------------------------------------------- training
  assign w_idxE    = PCE[INDEX_BITS+1:2];
  assign w_tagE    = PCE[31:INDEX_BITS+2];
  assign w_hitE    = r_valid[w_idxE] && (r_tag[w_idxE] == w_tagE);
  assign w_ctr_cur = r_ctr[w_idxE];

  assign MispredictE = UpdateE && (predict_taken_E != ActualTakenE);

  always_comb begin
    w_ctr_next = w_ctr_cur;
    w_alloc    = 1'b0;
    w_tgt_we   = 1'b0;
    if (w_hitE) begin
      if (IsJumpE) begin
        w_ctr_next = 2'b11;
        w_tgt_we   = 1'b1;
      end else if (ActualTakenE) begin
        w_ctr_next = (w_ctr_cur == 2'b11) ? 2'b11 : w_ctr_cur + 2'd1;
        w_tgt_we   = 1'b1;
      end else begin
        w_ctr_next = (w_ctr_cur == 2'b00) ? 2'b00 : w_ctr_cur - 2'd1;
      end
    end else if (ActualTakenE) begin
      // Only taken misses allocate; not-taken misses leave the table alone.
      w_ctr_next = IsJumpE ? 2'b11 : 2'b10;
      w_alloc    = 1'b1;
      w_tgt_we   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b01;
      end
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (UpdateE) begin
      r_ctr[w_idxE] <= w_ctr_next;
      if (w_alloc) begin
        r_valid[w_idxE] <= 1'b1;
      end
      if (r_branch_cnt != '1) begin
        r_branch_cnt <= r_branch_cnt + c_CNT_ONE;
      end
      if (MispredictE && (r_mispred_cnt != '1)) begin
        r_mispred_cnt <= r_mispred_cnt + c_CNT_ONE;
      end
    end
  end

  // Tag/target arrays carry no reset, but a write coinciding with reset is
  // still suppressed so the discarded update leaves no trace.
  always_ff @(posedge clk) begin
    if (rst && UpdateE) begin
      if (w_tgt_we) begin
        r_target[w_idxE] <= TargetE;
      end
      if (w_alloc) begin
        r_tag[w_idxE] <= w_tagE;
      end
    end
  end

  assign BranchCount     = r_branch_cnt;
  assign MispredictCount = r_mispred_cnt;

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Fetch-stage dynamic branch predictor. It supplies the per-instruction taken prediction and predicted target to fetch; that prediction then travels down the pipeline as predict_taken_D/predict_taken_E. It is a direct-mapped table of branch-target entries, each holding a valid bit, a tag, a target and a 2-bit saturating counter. It is trained from the execute stage once the real outcome is known, and it keeps branch and mispredict performance counters.

Parameters:
INDEX_BITS, 6, log2 of table entries (64 entries); index = PC[INDEX_BITS+1:2]
CNT_WIDTH, 32, width of each performance counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset (asserted at 0)
PCF  input  32  fetch PC to look up
predict_taken_F  output  1  prediction for PCF: taken
PredictTargetF  output  32  next PC for fetch: predicted target if taken, else PCF+4
UpdateE  input  1  execute holds a valid resolved branch/jump this cycle (already qualified by flush/stall)
IsJumpE  input  1  resolved instruction is JAL/JALR (unconditional)
ActualTakenE  input  1  real outcome of the instruction in execute
PCE  input  32  PC of the instruction in execute
TargetE  input  32  real target computed in execute
predict_taken_E  input  1  prediction made for that instruction in fetch
MispredictE  output  1  combinational: UpdateE && (predict_taken_E != ActualTakenE)
BranchCount  output  CNT_WIDTH  resolved updates seen
MispredictCount  output  CNT_WIDTH  mispredictions seen

Behaviour:
- Tag = PC[31:INDEX_BITS+2]. PC[1:0] is ignored everywhere.
- Lookup is combinational, zero latency from PCF.
  - hit = valid[idx] && tag[idx]==tagF.
  - predict_taken_F = hit && ctr[idx][1].
  - PredictTargetF = predict_taken_F ? target[idx] : PCF+4, with 32-bit wrap (0xFFFFFFFC+4 = 0).
- Reset (rst=0, takes effect immediately without a clock edge):
  - all valid bits = 0; all ctr = 2'b01; BranchCount = MispredictCount = 0.
  - Consequence: predict_taken_F = 0 and PredictTargetF = PCF+4 while in reset and after it.
  - Target and tag arrays need no reset.
  - Reset asserted mid-training discards any pending update that edge.
- Update happens on posedge clk only when UpdateE=1; idxE and tagE are taken from PCE.
  - Hit, conditional branch: ctr saturating +1 if ActualTakenE, else saturating -1 (11 stays 11, 00 stays 00). If ActualTakenE, target <= TargetE.
  - Hit, IsJumpE: ctr <= 11, target <= TargetE.
  - Miss (invalid or tag differs), ActualTakenE=1: allocate/replace. valid <= 1, tag <= tagE, target <= TargetE, ctr <= 11 if IsJumpE, else 10.
  - Miss, ActualTakenE=0: no state change (not-taken branches are never allocated).
- Simultaneous lookup and update to the same index in one cycle: lookup returns the pre-update state. There is no bypass.
- Counters:
  - BranchCount increments on every UpdateE.
  - MispredictCount increments when MispredictE=1.
  - Both saturate at all-ones and never wrap.
- UpdateE=0: no state change, regardless of the other E inputs.
- Aliasing: two PCs sharing an index but differing in tag replace each other only on a taken miss.

Test Plan:
1. Reset then PCF=0x100 -> predict_taken_F=0, PredictTargetF=0x104. Pulse rst low mid-run after training -> prediction drops to 0 immediately, counters read 0.
2. Train PCE=0x100, TargetE=0x40, ActualTakenE=1, one update -> PCF=0x100 gives predict_taken_F=1, PredictTargetF=0x40 (ctr=10). One not-taken update -> ctr=01, predict 0, target 0x104.
3. Five consecutive taken updates on 0x200 then two not-taken -> ctr path 10,11,11,11,11,10,01. Prediction stays 1 after the first not-taken and goes 0 after the second.
4. IsJumpE=1 at PCE=0x300, TargetE=0x80 -> ctr=11, immediate predict 0x80. Then PCE=0x300+(64<<2) taken to 0x90 -> entry replaced: 0x300 misses, the new PC predicts 0x90.
5. PCF=PCE=0x100 with UpdateE taken in the same cycle on an empty table -> predict_taken_F=0 in that cycle, 1 in the next.
6. Counters: 10 updates, of which 3 have predict_taken_E != ActualTakenE -> BranchCount=10, MispredictCount=3. With CNT_WIDTH=4 and 20 updates -> BranchCount holds 15.
